// File: rtl/full_adder_if.sv
// Operand/result bundle for full_adder.
// Counter signals exist only when FULL_ADDER_STATS_EN is defined.
interface full_adder_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             out_valid;
`ifdef FULL_ADDER_STATS_EN
    logic             clr_cnt;
    logic [CNT_W-1:0] op_cnt;
    logic [CNT_W-1:0] carry_cnt;

    modport master (
        output a, b, c, clr_cnt,
        input  sum, cout, out_valid, op_cnt, carry_cnt
    );
    modport slave (
        input  a, b, c, clr_cnt,
        output sum, cout, out_valid, op_cnt, carry_cnt
    );
`else
    modport master (
        output a, b, c,
        input  sum, cout, out_valid
    );
    modport slave (
        input  a, b, c,
        output sum, cout, out_valid
    );
`endif

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end
endinterface

// File: rtl/full_adder.sv
// Registered WIDTH-bit adder with carry-in/out, 1-cycle latency.
// Optional saturating statistics counters under FULL_ADDER_STATS_EN.
module full_adder #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    full_adder_if.slave bus
);
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("WIDTH must be in 1..64");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    logic [WIDTH:0]   w_total;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_valid;

    // Zero-extend to WIDTH+1 so the carry is kept.
    assign w_total = {1'b0, bus.a}
                   + {1'b0, bus.b}
                   + {{WIDTH{1'b0}}, bus.c};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_sum   <= w_total[WIDTH-1:0];
            r_cout  <= w_total[WIDTH];
            r_valid <= 1'b1;
        end
    end

    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.out_valid = r_valid;

`ifdef FULL_ADDER_STATS_EN
    logic [CNT_W-1:0] r_op_cnt;
    logic [CNT_W-1:0] r_carry_cnt;
    logic             w_op_sat;
    logic             w_carry_sat;

    assign w_op_sat    = &r_op_cnt;
    assign w_carry_sat = &r_carry_cnt;

    // Additions are counted at the edge that samples them.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.clr_cnt) begin
            r_op_cnt    <= '0;
            r_carry_cnt <= '0;
        end else begin
            if (!w_op_sat) begin
                r_op_cnt <= r_op_cnt + 1'b1;
            end
            if (w_total[WIDTH] && !w_carry_sat) begin
                r_carry_cnt <= r_carry_cnt + 1'b1;
            end
        end
    end

    assign bus.op_cnt    = r_op_cnt;
    assign bus.carry_cnt = r_carry_cnt;
`endif
endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH=1 (CNT_W=4) and WIDTH=8.
// Counter checks are compiled in with FULL_ADDER_STATS_EN.
module tb_full_adder;
    logic clk;
    logic rst_n;

    full_adder_if #(.WIDTH(1), .CNT_W(4))  if1 ();
    full_adder_if #(.WIDTH(8), .CNT_W(16)) if8 ();

    full_adder #(.WIDTH(1), .CNT_W(4)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );
    full_adder #(.WIDTH(8), .CNT_W(16)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vecs  = 0;
    int fails = 0;

    // Reference state: expected registered results and counters.
    int exp1  = 0;
    int exp8  = 0;
    bit expv  = 1'b0;
    int op    = 0;
    int cy    = 0;
    int clrv  = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(
        input int a1, input int b1, input int c1,
        input int a8, input int b8, input int c8,
        input bit rst, input bit clr
    );
        int s1;
        int s8;
        if1.a = 1'(a1);
        if1.b = 1'(b1);
        if1.c = 1'(c1);
        if8.a = 8'(a8);
        if8.b = 8'(b8);
        if8.c = 1'(c8);
        rst_n = rst;
`ifdef FULL_ADDER_STATS_EN
        if1.clr_cnt = clr;
        if8.clr_cnt = 1'b0;
`endif
        @(posedge clk);
        #1;
        s1 = a1 + b1 + c1;
        s8 = a8 + b8 + c8;
        if (!rst) begin
            exp1 = 0;
            exp8 = 0;
            expv = 1'b0;
            op   = 0;
            cy   = 0;
        end else begin
            exp1 = s1;
            exp8 = s8;
            expv = 1'b1;
            if (clr) begin
                op = 0;
                cy = 0;
            end else begin
                if (op < 15) op++;
                if (s1 >= 2 && cy < 15) cy++;
            end
        end
        clrv = clr;
        chk("w1_result", int'({if1.cout, if1.sum}), exp1);
        chk("w8_result", int'({if8.cout, if8.sum}), exp8);
        chk("w1_valid", int'(if1.out_valid), int'(expv));
        chk("w8_valid", int'(if8.out_valid), int'(expv));
`ifdef FULL_ADDER_STATS_EN
        chk("op_cnt", int'(if1.op_cnt), op);
        chk("carry_cnt", int'(if1.carry_cnt), cy);
`endif
    endtask

    int tbl [8] = '{0, 1, 1, 2, 1, 2, 2, 3};

    initial begin
        rst_n = 1'b0;
        if1.a = '0; if1.b = '0; if1.c = 1'b0;
        if8.a = '0; if8.b = '0; if8.c = 1'b0;
`ifdef FULL_ADDER_STATS_EN
        if1.clr_cnt = 1'b0;
        if8.clr_cnt = 1'b0;
`endif
        // Reset state, with non-zero inputs that must be discarded.
        step(1, 1, 1, 255, 255, 1, 1'b0, 1'b0);
        step(1, 0, 1, 17, 3, 1, 1'b0, 1'b0);

        // Exhaustive WIDTH=1 truth table, also against the literal table.
        for (int i = 0; i < 8; i++) begin
            step((i >> 2) & 1, (i >> 1) & 1, i & 1,
                 i * 31, 255 - i, i & 1, 1'b1, 1'b0);
            chk("w1_table", int'({if1.cout, if1.sum}), tbl[i]);
        end

        // WIDTH=8 carry boundaries.
        step(0, 0, 0, 8'hFF, 8'h01, 0, 1'b1, 1'b0);
        chk("w8_ff01", int'({if8.cout, if8.sum}), 9'h100);
        step(1, 1, 1, 8'hFF, 8'hFF, 1, 1'b1, 1'b0);
        chk("w8_wrap", int'({if8.cout, if8.sum}), 9'h1FF);
        step(0, 0, 0, 0, 0, 0, 1'b1, 1'b0);

        // Random back-to-back additions.
        for (int i = 0; i < 40; i++) begin
            step(int'($urandom_range(1)), int'($urandom_range(1)),
                 int'($urandom_range(1)), int'($urandom_range(255)),
                 int'($urandom_range(255)), int'($urandom_range(1)),
                 1'b1, 1'b0);
        end

        // Mid-stream reset with all inputs high.
        step(1, 1, 1, 255, 255, 1, 1'b0, 1'b0);
        chk("rst_mid_valid", int'(if8.out_valid), 0);
        step(1, 1, 1, 255, 255, 1, 1'b1, 1'b0);
        chk("rst_rel_valid", int'(if8.out_valid), 1);

        // Saturation run: 20 carrying additions after a fresh reset.
        step(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1, 1, i & 1, i, 200, 1, 1'b1, 1'b0);
        end
`ifdef FULL_ADDER_STATS_EN
        chk("op_sat", int'(if1.op_cnt), 15);
        chk("carry_sat", int'(if1.carry_cnt), 15);
`endif

        // Counter clear mid-stream; results unaffected.
        step(1, 0, 0, 10, 20, 0, 1'b1, 1'b0);
        step(1, 1, 0, 100, 200, 1, 1'b1, 1'b1);
        chk("clr_result", int'({if1.cout, if1.sum}), 2);
`ifdef FULL_ADDER_STATS_EN
        chk("clr_op", int'(if1.op_cnt), 0);
`endif
        step(1, 1, 1, 1, 2, 0, 1'b1, 1'b0);
`ifdef FULL_ADDER_STATS_EN
        chk("resume_op", int'(if1.op_cnt), 1);
        chk("resume_cy", int'(if1.carry_cnt), 1);
`endif
        for (int i = 0; i < 10; i++) begin
            step(int'($urandom_range(1)), int'($urandom_range(1)),
                 int'($urandom_range(1)), int'($urandom_range(255)),
                 int'($urandom_range(255)), int'($urandom_range(1)),
                 1'b1, bit'(i == 5));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, fails);
        $finish;
    end
endmodule
